// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I main controller.
// ILLEGAL_TRAP_EN adds the StTrap state to state_t.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
    StJal
`ifdef ILLEGAL_TRAP_EN
    ,
    StTrap
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2} srca_t;
  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} srcb_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_MEMDATA = 2'd1, RES_ALU = 2'd2} res_t;
  typedef enum logic [1:0] {IMM_I = 2'd0, IMM_S = 2'd1, IMM_B = 2'd2, IMM_J = 2'd3} imm_t;

  // Coarse ALU request from the FSM; ALUOP_FUNCT defers to funct3/funct7.
  typedef enum logic [1:0] {ALUOP_ADD = 2'd0, ALUOP_SUB = 2'd1, ALUOP_FUNCT = 2'd2} alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM request and instruction fields.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_ctrl_o
);

  // Decode ALU operation; funct7b5 only means subtract for R-type (opcode bit 5 set).
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b111:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core (lw, sw, R, I-ALU, beq, jal).
// Optional macro ILLEGAL_TRAP_EN: adds illegal_instr_o and a sticky TRAP state.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] imm_src_o,
  output logic [2:0] alu_ctrl_o,
  output logic       mem_timeout_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr_o
`endif
);

  localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CntW-1:0] CntLast = (MAX_WAIT == 0) ? '0 : CntW'(MAX_WAIT - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            waiting;
  logic            timeout;
  alu_op_t         alu_op;

  // Wait states are those that stall on mem_ready; the abort fires on the MAX_WAIT-th idle cycle.
  always_comb begin
    waiting = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    timeout = (MAX_WAIT != 0) && waiting && !mem_ready_i && (wait_cnt_q == CntLast);
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and wait-counter logic; counter clears whenever the state moves or on abort.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (timeout) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch:    if (mem_ready_i) state_d = StDecode;
        StDecode: begin
          case (opcode_i)
            OP_LW, OP_SW: state_d = StMemAdr;
            OP_R:         state_d = StExecR;
            OP_I:         state_d = StExecI;
            OP_BEQ:       state_d = StBeq;
            OP_JAL:       state_d = StJal;
`ifdef ILLEGAL_TRAP_EN
            default:      state_d = StTrap;
`else
            default:      state_d = StFetch;
`endif
          endcase
        end
        StMemAdr:   state_d = (opcode_i == OP_SW) ? StMemWrite : StMemRead;
        StMemRead:  if (mem_ready_i) state_d = StMemWb;
        StMemWb:    state_d = StFetch;
        StMemWrite: if (mem_ready_i) state_d = StFetch;
        StExecR:    state_d = StAluWb;
        StExecI:    state_d = StAluWb;
        StAluWb:    state_d = StFetch;
        StBeq:      state_d = StFetch;
        StJal:      state_d = StAluWb;
`ifdef ILLEGAL_TRAP_EN
        StTrap:     state_d = StTrap;
`endif
        default:    state_d = StFetch;
      endcase
      // Only a stalled wait state keeps counting.
      if (waiting && !mem_ready_i) wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  // Output decode from state; abort and reset force every enable low.
  always_comb begin
    pc_write_o    = 1'b0;
    adr_src_o     = 1'b0;
    mem_write_o   = 1'b0;
    ir_write_o    = 1'b0;
    reg_write_o   = 1'b0;
    result_src_o  = RES_ALUOUT;
    alu_src_a_o   = SRCA_PC;
    alu_src_b_o   = SRCB_RS2;
    imm_src_o     = IMM_I;
    alu_op        = ALUOP_ADD;
    mem_timeout_o = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr_o = 1'b0;
`endif
    unique case (state_q)
      StFetch: begin
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALU;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      StDecode: begin
        alu_src_a_o = SRCA_OLDPC;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = IMM_J;
      end
      StMemAdr: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = (opcode_i == OP_SW) ? IMM_S : IMM_I;
      end
      StMemRead:  adr_src_o = 1'b1;
      StMemWb: begin
        result_src_o = RES_MEMDATA;
        reg_write_o  = 1'b1;
      end
      StMemWrite: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
      end
      StExecR: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_RS2;
        alu_op      = ALUOP_FUNCT;
      end
      StExecI: begin
        alu_src_a_o = SRCA_RS1;
        alu_src_b_o = SRCB_IMM;
        imm_src_o   = IMM_I;
        alu_op      = ALUOP_FUNCT;
      end
      StAluWb: begin
        result_src_o = RES_ALUOUT;
        reg_write_o  = 1'b1;
      end
      StBeq: begin
        alu_src_a_o  = SRCA_RS1;
        alu_src_b_o  = SRCB_RS2;
        imm_src_o    = IMM_B;
        alu_op       = ALUOP_SUB;
        result_src_o = RES_ALUOUT;
        pc_write_o   = zero_i;
      end
      StJal: begin
        alu_src_a_o  = SRCA_OLDPC;
        alu_src_b_o  = SRCB_FOUR;
        result_src_o = RES_ALUOUT;
        pc_write_o   = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      StTrap:     illegal_instr_o = 1'b1;
`endif
      default: ;
    endcase
    if (timeout || !rst_n) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
    end
    mem_timeout_o = timeout && rst_n;
  end

  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3_i),
    .funct7b5_i (funct7b5_i),
    .op5_i      (opcode_i[5]),
    .alu_ctrl_o (alu_ctrl_o)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl (MAX_WAIT = 4); per-cycle expectations go through a
// scoreboard queue. Honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_ctrl;

  localparam int D   = -1;  // don't care
  localparam int ADD = 0;
  localparam int SUB = 1;
  localparam int AND = 2;
  localparam int OR  = 3;
  localparam int SLT = 5;

  typedef struct {
    string       tag;
    logic        rstn;
    logic        rdy;
    logic        z;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        ill;
    logic [16:0] val;
    logic [16:0] mask;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode_i = 7'b0110011;
  logic [2:0] funct3_i = 3'b000;
  logic       funct7b5_i = 1'b1;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b1;
  logic       pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o, mem_timeout_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o;
  logic [2:0] alu_ctrl_o;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_instr_o;
`endif

  logic [6:0] cur_op = 7'b0110011;
  logic [2:0] cur_f3 = 3'b000;
  logic       cur_f7 = 1'b1;
  vec_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode_i      (opcode_i),
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .pc_write_o    (pc_write_o),
    .adr_src_o     (adr_src_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_write_o   (reg_write_o),
    .result_src_o  (result_src_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .imm_src_o     (imm_src_o),
    .alu_ctrl_o    (alu_ctrl_o),
    .mem_timeout_o (mem_timeout_o)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_instr_o (illegal_instr_o)
`endif
  );

  function automatic logic [16:0] obs_vec();
    return {pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o, result_src_o,
            alu_src_a_o, alu_src_b_o, imm_src_o, alu_ctrl_o, mem_timeout_o};
  endfunction

  function automatic void put(inout vec_t r, input int lsb, input int w, input int v);
    if (v >= 0) begin
      for (int k = 0; k < w; k++) begin
        r.val[lsb+k]  = v[k];
        r.mask[lsb+k] = 1'b1;
      end
    end
  endfunction

  function automatic vec_t mk(string tag, logic rdy, logic z, int pcw, int adr, int mw, int irw,
                              int rw, int res, int a, int b, int imm, int alu, int to);
    vec_t r;
    r.tag = tag; r.rstn = 1'b1; r.rdy = rdy; r.z = z;
    r.op = cur_op; r.f3 = cur_f3; r.f7b5 = cur_f7; r.ill = 1'b0;
    r.val = '0; r.mask = '0;
    put(r, 16, 1, pcw); put(r, 15, 1, adr); put(r, 14, 1, mw); put(r, 13, 1, irw);
    put(r, 12, 1, rw);  put(r, 10, 2, res); put(r, 8, 2, a);   put(r, 6, 2, b);
    put(r, 4, 2, imm);  put(r, 1, 3, alu);  put(r, 0, 1, to);
    return r;
  endfunction

  function automatic vec_t e_fetch(string t, logic rdy);
    return mk(t, rdy, 0, rdy ? 1 : 0, 0, 0, rdy ? 1 : 0, 0, rdy ? 2 : D, 0, 2, D, ADD, 0);
  endfunction
  function automatic vec_t e_decode(string t);
    return mk(t, 1, 0, 0, D, 0, 0, 0, D, 1, 1, 3, ADD, 0);
  endfunction
  function automatic vec_t e_memadr(string t, int imm);
    return mk(t, 1, 0, 0, D, 0, 0, 0, D, 2, 1, imm, ADD, 0);
  endfunction
  function automatic vec_t e_memread(string t, logic rdy);
    return mk(t, rdy, 0, 0, 1, 0, 0, 0, D, D, D, D, D, 0);
  endfunction
  function automatic vec_t e_memwb(string t);
    return mk(t, 1, 0, 0, D, 0, 0, 1, 1, D, D, D, D, 0);
  endfunction
  function automatic vec_t e_memwrite(string t, logic rdy);
    return mk(t, rdy, 0, 0, 1, 1, 0, 0, D, D, D, D, D, 0);
  endfunction
  function automatic vec_t e_exec(string t, int b, int alu);
    return mk(t, 1, 0, 0, D, 0, 0, 0, D, 2, b, D, alu, 0);
  endfunction
  function automatic vec_t e_aluwb(string t);
    return mk(t, 1, 0, 0, D, 0, 0, 1, 0, D, D, D, D, 0);
  endfunction
  function automatic vec_t e_beq(string t, logic z);
    return mk(t, 1, z, z ? 1 : 0, D, 0, 0, 0, 0, 2, 0, D, SUB, 0);
  endfunction
  function automatic vec_t e_jal(string t);
    return mk(t, 1, 0, 1, D, 0, 0, 0, 0, 1, 2, D, ADD, 0);
  endfunction
  function automatic vec_t e_timeout(string t);
    return mk(t, 0, 0, 0, D, 0, 0, 0, D, D, D, D, D, 1);
  endfunction
  function automatic vec_t e_reset(string t);
    vec_t r;
    r = mk(t, 1, 0, 0, D, 0, 0, 0, D, D, D, D, D, 0);
    r.rstn = 1'b0;
    return r;
  endfunction

  function automatic void set_instr(logic [6:0] op, logic [2:0] f3, logic f7);
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
  endfunction

  task automatic test_reset();
    vec_t v[$];
    vec_t e;
    set_instr(7'b0110011, 3'b000, 1'b1);  // sub
    v.push_back(e_reset("rst_hold0"));
    v.push_back(e_reset("rst_hold1"));
    v.push_back(e_fetch("rst_fetch", 1));
    v.push_back(e_decode("sub_decode"));
    v.push_back(e_exec("sub_exec", 0, SUB));
    v.push_back(e_aluwb("sub_aluwb"));
    v.push_back(e_fetch("sub_back_fetch", 0));
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rstn; mem_ready_i = v[i].rdy; zero_i = v[i].z;
      opcode_i = v[i].op; funct3_i = v[i].f3; funct7b5_i = v[i].f7b5;
      sb.push_back(v[i]);
      #2;
      e = sb.pop_front();
      n_vec++;
      if (((obs_vec() ^ e.val) & e.mask) !== '0) begin
        n_err++;
        $display("FAIL %s: got %05h want %05h mask %05h", e.tag, obs_vec(), e.val, e.mask);
      end
    end
  endtask

  task automatic test_alu_ops();
    vec_t v[$];
    vec_t e;
    set_instr(7'b0110011, 3'b010, 1'b0);
    v.push_back(e_fetch("slt_fetch", 1)); v.push_back(e_decode("slt_decode"));
    v.push_back(e_exec("slt_exec", 0, SLT)); v.push_back(e_aluwb("slt_aluwb"));
    set_instr(7'b0010011, 3'b000, 1'b1);  // addi must not subtract
    v.push_back(e_fetch("addi_fetch", 1)); v.push_back(e_decode("addi_decode"));
    v.push_back(e_exec("addi_exec", 1, ADD)); v.push_back(e_aluwb("addi_aluwb"));
    set_instr(7'b0010011, 3'b110, 1'b0);
    v.push_back(e_fetch("ori_fetch", 1)); v.push_back(e_decode("ori_decode"));
    v.push_back(e_exec("ori_exec", 1, OR)); v.push_back(e_aluwb("ori_aluwb"));
    set_instr(7'b0110011, 3'b111, 1'b0);
    v.push_back(e_fetch("and_fetch", 1)); v.push_back(e_decode("and_decode"));
    v.push_back(e_exec("and_exec", 0, AND)); v.push_back(e_aluwb("and_aluwb"));
    set_instr(7'b0110011, 3'b000, 1'b0);
    v.push_back(e_fetch("add_fetch", 1)); v.push_back(e_decode("add_decode"));
    v.push_back(e_exec("add_exec", 0, ADD)); v.push_back(e_aluwb("add_aluwb"));
    v.push_back(e_fetch("alu_back_fetch", 0));
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rstn; mem_ready_i = v[i].rdy; zero_i = v[i].z;
      opcode_i = v[i].op; funct3_i = v[i].f3; funct7b5_i = v[i].f7b5;
      sb.push_back(v[i]);
      #2;
      e = sb.pop_front();
      n_vec++;
      if (((obs_vec() ^ e.val) & e.mask) !== '0) begin
        n_err++;
        $display("FAIL %s: got %05h want %05h mask %05h", e.tag, obs_vec(), e.val, e.mask);
      end
    end
  endtask

  task automatic test_lw_wait();
    vec_t v[$];
    vec_t e;
    set_instr(7'b0000011, 3'b010, 1'b0);
    v.push_back(e_fetch("lw_fetch", 1)); v.push_back(e_decode("lw_decode"));
    v.push_back(e_memadr("lw_memadr", 0));
    v.push_back(e_memread("lw_wait1", 0)); v.push_back(e_memread("lw_wait2", 0));
    v.push_back(e_memread("lw_wait3", 0)); v.push_back(e_memread("lw_ready", 1));
    v.push_back(e_memwb("lw_memwb"));
    v.push_back(e_fetch("lw_back_fetch", 0));  // 9th cycle: lw took 8
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rstn; mem_ready_i = v[i].rdy; zero_i = v[i].z;
      opcode_i = v[i].op; funct3_i = v[i].f3; funct7b5_i = v[i].f7b5;
      sb.push_back(v[i]);
      #2;
      e = sb.pop_front();
      n_vec++;
      if (((obs_vec() ^ e.val) & e.mask) !== '0) begin
        n_err++;
        $display("FAIL %s: got %05h want %05h mask %05h", e.tag, obs_vec(), e.val, e.mask);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    vec_t e;
    set_instr(7'b0100011, 3'b010, 1'b0);
    v.push_back(e_fetch("sw_fetch", 1)); v.push_back(e_decode("sw_decode"));
    v.push_back(e_memadr("sw_memadr", 1)); v.push_back(e_memwrite("sw_write", 1));
    set_instr(7'b1100011, 3'b000, 1'b0);
    v.push_back(e_fetch("beq1_fetch", 1)); v.push_back(e_decode("beq1_decode"));
    v.push_back(e_beq("beq_taken", 1));
    v.push_back(e_fetch("beq0_fetch", 1)); v.push_back(e_decode("beq0_decode"));
    v.push_back(e_beq("beq_not_taken", 0));
    set_instr(7'b1101111, 3'b000, 1'b0);
    v.push_back(e_fetch("jal_fetch", 1)); v.push_back(e_decode("jal_decode"));
    v.push_back(e_jal("jal_jal")); v.push_back(e_aluwb("jal_aluwb"));
    v.push_back(e_fetch("b2b_back_fetch", 0));
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rstn; mem_ready_i = v[i].rdy; zero_i = v[i].z;
      opcode_i = v[i].op; funct3_i = v[i].f3; funct7b5_i = v[i].f7b5;
      sb.push_back(v[i]);
      #2;
      e = sb.pop_front();
      n_vec++;
      if (((obs_vec() ^ e.val) & e.mask) !== '0) begin
        n_err++;
        $display("FAIL %s: got %05h want %05h mask %05h", e.tag, obs_vec(), e.val, e.mask);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t v[$];
    vec_t e;
    set_instr(7'b0100011, 3'b010, 1'b0);
    v.push_back(e_fetch("to_sw_fetch", 1)); v.push_back(e_decode("to_sw_decode"));
    v.push_back(e_memadr("to_sw_memadr", 1));
    v.push_back(e_memwrite("to_wait1", 0)); v.push_back(e_memwrite("to_wait2", 0));
    v.push_back(e_memwrite("to_wait3", 0)); v.push_back(e_timeout("to_memwrite_abort"));
    v.push_back(e_fetch("to_fetch1", 0)); v.push_back(e_fetch("to_fetch2", 0));
    v.push_back(e_fetch("to_fetch3", 0)); v.push_back(e_timeout("to_fetch_abort"));
    v.push_back(e_fetch("to_fetch_cleared", 0));
    v.push_back(e_fetch("win_fetch", 1)); v.push_back(e_decode("win_decode"));
    v.push_back(e_memadr("win_memadr", 1));
    v.push_back(e_memwrite("win_wait1", 0)); v.push_back(e_memwrite("win_wait2", 0));
    v.push_back(e_memwrite("win_wait3", 0)); v.push_back(e_memwrite("win_ready_at_max", 1));
    v.push_back(e_fetch("win_back_fetch", 0));
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rstn; mem_ready_i = v[i].rdy; zero_i = v[i].z;
      opcode_i = v[i].op; funct3_i = v[i].f3; funct7b5_i = v[i].f7b5;
      sb.push_back(v[i]);
      #2;
      e = sb.pop_front();
      n_vec++;
      if (((obs_vec() ^ e.val) & e.mask) !== '0) begin
        n_err++;
        $display("FAIL %s: got %05h want %05h mask %05h", e.tag, obs_vec(), e.val, e.mask);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v[$];
    vec_t e;
    set_instr(7'b0000000, 3'b000, 1'b0);
    v.push_back(e_fetch("ill_fetch", 1)); v.push_back(e_decode("ill_decode"));
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      e = mk("ill_trap", 1, 0, 0, D, 0, 0, 0, D, D, D, D, D, 0);
      e.ill = 1'b1;
      v.push_back(e);
    end
    v.push_back(e_reset("ill_reset"));
    v.push_back(e_fetch("ill_after_reset", 0));
`else
    v.push_back(e_fetch("ill_nop_fetch", 0));
`endif
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rstn; mem_ready_i = v[i].rdy; zero_i = v[i].z;
      opcode_i = v[i].op; funct3_i = v[i].f3; funct7b5_i = v[i].f7b5;
      sb.push_back(v[i]);
      #2;
      e = sb.pop_front();
      n_vec++;
      if (((obs_vec() ^ e.val) & e.mask) !== '0) begin
        n_err++;
        $display("FAIL %s: got %05h want %05h mask %05h", e.tag, obs_vec(), e.val, e.mask);
      end
`ifdef ILLEGAL_TRAP_EN
      n_vec++;
      if (illegal_instr_o !== e.ill) begin
        n_err++;
        $display("FAIL %s illegal_instr: got %b want %b", e.tag, illegal_instr_o, e.ill);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    vec_t v[$];
    vec_t e;
    set_instr(7'b0100011, 3'b010, 1'b0);
    v.push_back(e_fetch("rm_fetch", 1)); v.push_back(e_decode("rm_decode"));
    v.push_back(e_memadr("rm_memadr", 1));
    v.push_back(e_reset("rm_reset_no_write"));
    v.push_back(e_fetch("rm_fetch_idle", 0));
    v.push_back(e_fetch("rm_refetch", 1)); v.push_back(e_decode("rm_redecode"));
    v.push_back(e_memadr("rm_rememadr", 1)); v.push_back(e_memwrite("rm_write", 1));
    v.push_back(e_fetch("rm_back_fetch", 0));
    foreach (v[i]) begin
      @(negedge clk);
      rst_n = v[i].rstn; mem_ready_i = v[i].rdy; zero_i = v[i].z;
      opcode_i = v[i].op; funct3_i = v[i].f3; funct7b5_i = v[i].f7b5;
      sb.push_back(v[i]);
      #2;
      e = sb.pop_front();
      n_vec++;
      if (((obs_vec() ^ e.val) & e.mask) !== '0) begin
        n_err++;
        $display("FAIL %s: got %05h want %05h mask %05h", e.tag, obs_vec(), e.val, e.mask);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_lw_wait();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
